// File: rtl/pc_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pc_sequencer : 2-bit program counter sequencer (IDLE/FETCH/EXEC/HALT)  |
// | with a 4-entry instruction set (HLT, INC, JNO, CLO) and overflow flag. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module pc_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] instr,
  input  logic       instr_valid,
  input  logic [1:0] jump_target,
  output logic       fetch_req,
  output logic [1:0] pc,
  output logic       ov,
  output logic       retire,
  output logic       halted,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [1:0] C_OP_HLT = 2'b00;
  localparam logic [1:0] C_OP_INC = 2'b01;
  localparam logic [1:0] C_OP_JNO = 2'b10;
  localparam logic [1:0] C_OP_CLO = 2'b11;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_pc;
  logic [1:0] w_pc_nxt;
  logic       r_ov;
  logic       w_ov_nxt;
  logic [1:0] r_instr;
  logic [1:0] w_instr_nxt;
  logic [2:0] w_pc_inc;

  // Bit 2 is the carry out of the 2-bit increment, i.e. the 3 -> 0 wrap.
  assign w_pc_inc = {1'b0, r_pc} + 3'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_pc    <= 2'b00;
      r_ov    <= 1'b0;
      r_instr <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ov    <= w_ov_nxt;
      r_instr <= w_instr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ov_nxt    = r_ov;
    w_instr_nxt = r_instr;
    case (r_state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          w_pc_nxt    = 2'b00;
          w_ov_nxt    = 1'b0;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (instr_valid) begin
          w_instr_nxt = instr;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_nxt = ST_FETCH;
        case (r_instr)
          C_OP_HLT: w_state_nxt = ST_HALT;
          C_OP_INC: begin
            w_pc_nxt = w_pc_inc[1:0];
            if (w_pc_inc[2]) w_ov_nxt = 1'b1;
          end
          C_OP_JNO: begin
            if (r_ov) begin
              w_pc_nxt = w_pc_inc[1:0];
              w_ov_nxt = 1'b0;
            end else begin
              w_pc_nxt = jump_target;
            end
          end
          C_OP_CLO: begin
            w_pc_nxt = w_pc_inc[1:0];
            w_ov_nxt = 1'b0;
          end
          default: w_state_nxt = ST_IDLE;
        endcase
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign fetch_req = (r_state == ST_FETCH);
  assign retire    = (r_state == ST_EXEC);
  assign halted    = (r_state == ST_HALT);
  assign busy      = (r_state == ST_FETCH) || (r_state == ST_EXEC);
  assign pc        = r_pc;
  assign ov        = r_ov;

endmodule
`default_nettype wire
